// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Response checker for a combinational DUT. Each accepted sample pairs the
//   applied input vector with the observed output. The checker compares that
//   output against the expected truth table, counts the failures and records
//   which vectors were seen. One pass is NUM_CHECKS samples long, and then the
//   checker reports pass or fail.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | after reset, no pass run yet; waiting for start
//   RUN   | accepting samples; start ignored
//   DONE  | pass finished, results held; start begins a new pass
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          begin a pass (taken in IDLE or DONE only)
//   in_valid       in_vec / y_obs carry a sample this cycle
//   in_vec         input vector applied to the DUT
//   y_obs          observed DUT output for in_vec
//   busy           high in RUN
//   done           high in DONE
//   pass           valid with done: no errors and full vector coverage
//   mismatch       one-cycle pulse after a failing sample
//   err_count      failing samples this pass (saturating)
//   first_err_vec  in_vec of the first failing sample
//   first_err_vld  first_err_vec holds a captured value
//   coverage       bit i set once vector i has been sampled this pass
module truth_table_checker #(
    parameter int                  N_IN       = 3,
    parameter logic [2**N_IN-1:0]  TRUTH      = 8'h96,
    parameter int                  NUM_CHECKS = 11,
    parameter int                  ERR_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [N_IN-1:0]      in_vec,
    input  logic                 y_obs,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 mismatch,
    output logic [ERR_W-1:0]     err_count,
    output logic [N_IN-1:0]      first_err_vec,
    output logic                 first_err_vld,
    output logic [2**N_IN-1:0]   coverage
);

    localparam int NV    = 2**N_IN;
    localparam int CNT_W = $clog2(NUM_CHECKS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_CHECKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    remaining;
    logic                take_start;
    logic                accept;
    logic                last;
    logic                exp_bit;
    logic                fail;
    logic [NV-1:0]       cov_nxt;
    logic [ERR_W-1:0]    err_nxt;

    always_comb begin
        take_start = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        exp_bit    = 1'b0;
        fail       = 1'b0;
        cov_nxt    = coverage;
        err_nxt    = err_count;
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;

        take_start = start && (state != RUN);
        accept     = in_valid && (state == RUN);
        // remaining counts down from NUM_CHECKS; the sample seen at 1 ends the pass
        last       = accept && (remaining == CNT_LAST);
        exp_bit    = TRUTH[in_vec];
        // case inequality so an X/Z on y_obs is a failure in 4-state simulation
        fail       = accept && (y_obs !== exp_bit);
        cov_nxt    = coverage | (NV'(1) << in_vec);
        if (fail && (err_count != {ERR_W{1'b1}}))
            err_nxt = err_count + 1'b1;

        case (state)
            IDLE:    if (take_start) state_nxt = RUN;
            RUN:     if (last)       state_nxt = DONE;
            DONE:    if (take_start) state_nxt = RUN;
            default:                 state_nxt = IDLE;
        endcase

        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining     <= '0;
            pass          <= 1'b0;
            mismatch      <= 1'b0;
            err_count     <= '0;
            first_err_vec <= '0;
            first_err_vld <= 1'b0;
            coverage      <= '0;
        end else begin
            mismatch <= 1'b0;
            if (take_start) begin
                remaining     <= CNT_LOAD;
                pass          <= 1'b0;
                err_count     <= '0;
                first_err_vec <= '0;
                first_err_vld <= 1'b0;
                coverage      <= '0;
            end else if (accept) begin
                remaining <= remaining - 1'b1;
                coverage  <= cov_nxt;
                err_count <= err_nxt;
                if (fail) begin
                    mismatch <= 1'b1;
                    if (!first_err_vld) begin
                        first_err_vec <= in_vec;
                        first_err_vld <= 1'b1;
                    end
                end
                // pass is judged on the values that include this final sample
                if (last)
                    pass <= (err_nxt == '0) && (&cov_nxt);
            end
        end
    end

endmodule
